// File: rtl/bus_wr_decode_pkg.sv
// Shared write/read target codes and default widths for the datapath bus.
// The bus multiplexer's read-select decode uses the same code constants.
package bus_wr_decode_pkg;

    localparam int N_DEF      = 17;
    localparam int W_DEF      = 12;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [3:0] {
        WR_NONE = 4'd0,
        WR_AR   = 4'd1,
        WR_PC   = 4'd2,
        WR_IR   = 4'd4,
        WR_AC   = 4'd5,
        WR_R1   = 4'd7,
        WR_R2   = 4'd8,
        WR_R3   = 4'd9,
        WR_R4   = 4'd10,
        WR_DM   = 4'd12
    } wr_code_e;

    // Codes with no write target; code 13 is instruction memory, read-only on this bus.
    function automatic logic is_unused_code(input logic [3:0] code);
        return (code == 4'd3) || (code == 4'd6) || (code == 4'd11) ||
               (code == 4'd13) || (code == 4'd14) || (code == 4'd15);
    endfunction

endpackage

// File: rtl/bus_wr_decode_pc_reg.sv
// Program counter: bus load takes priority over increment; increment wraps.
module pc_reg
    import bus_wr_decode_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/bus_wr_decode.sv
// Write-side bus decode: latches the bus into AR/PC/IR/AC/R1-R4 or issues a DM write strobe.
// Optional macro BUS_WR_ERR_CNT_EN adds a saturating count of cycles carrying unused write codes.
module bus_wr_decode
    import bus_wr_decode_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int W      = W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        write_en,
    input  logic [N-1:0]      busin,
    input  logic              pc_inc,
    input  logic              ac_clr,
    input  logic              alu_we,
    input  logic [W-1:0]      alu_out,
    output logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] pc,
    output logic [W-1:0]      ir,
    output logic [W-1:0]      ac,
    output logic [W-1:0]      r1,
    output logic [W-1:0]      r2,
    output logic [W-1:0]      r3,
    output logic [W-1:0]      r4,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [W-1:0]      dm_wdata
`ifdef BUS_WR_ERR_CNT_EN
    ,
    output logic [7:0]        wr_err_cnt
`endif
);

    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [W-1:0]      ir_q, ir_d;
    logic [W-1:0]      ac_q, ac_d;
    logic [W-1:0]      r1_q, r1_d;
    logic [W-1:0]      r2_q, r2_d;
    logic [W-1:0]      r3_q, r3_d;
    logic [W-1:0]      r4_q, r4_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [W-1:0]      dm_wdata_q, dm_wdata_d;

    logic [W-1:0]      bus_w;
    logic [ADDR_W-1:0] bus_a;

    assign bus_w = busin[W-1:0];
    assign bus_a = busin[ADDR_W-1:0];

    generate
        if (N > W) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^busin[N-1:W];
        end
    endgenerate

    pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (write_en == WR_PC),
        .load_val_i (bus_a),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        ar_d       = ar_q;
        ir_d       = ir_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        r4_d       = r4_q;
        dm_we_d    = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        case (write_en)
            WR_AR: ar_d = bus_a;
            WR_IR: ir_d = bus_w;
            WR_R1: r1_d = bus_w;
            WR_R2: r2_d = bus_w;
            WR_R3: r3_d = bus_w;
            WR_R4: r4_d = bus_w;
            WR_DM: begin
                // Address is the AR value held this cycle, not any pending update.
                dm_we_d    = 1'b1;
                dm_addr_d  = ar_q;
                dm_wdata_d = bus_w;
            end
            default: ;
        endcase
    end

    // Lower-priority AC sources in the same cycle are dropped.
    always_comb begin
        ac_d = ac_q;
        if (ac_clr) begin
            ac_d = '0;
        end else if (write_en == WR_AC) begin
            ac_d = bus_w;
        end else if (alu_we) begin
            ac_d = alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q       <= '0;
            ir_q       <= '0;
            ac_q       <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            r4_q       <= '0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
        end else begin
            ar_q       <= ar_d;
            ir_q       <= ir_d;
            ac_q       <= ac_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            r4_q       <= r4_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    assign ar       = ar_q;
    assign ir       = ir_q;
    assign ac       = ac_q;
    assign r1       = r1_q;
    assign r2       = r2_q;
    assign r3       = r3_q;
    assign r4       = r4_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;

`ifdef BUS_WR_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (is_unused_code(write_en) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wr_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bus_wr_decode.sv
// Directed, table-driven bench for bus_wr_decode; the error-counter sequence runs only
// when BUS_WR_ERR_CNT_EN is defined.
module tb_bus_wr_decode;

    logic        clk;
    logic        rst_n;
    logic [3:0]  write_en;
    logic [16:0] busin;
    logic        pc_inc;
    logic        ac_clr;
    logic        alu_we;
    logic [11:0] alu_out;
    logic [7:0]  ar, pc, dm_addr;
    logic [11:0] ir, ac, r1, r2, r3, r4, dm_wdata;
    logic        dm_we;
`ifdef BUS_WR_ERR_CNT_EN
    logic [7:0]  wr_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bus_wr_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .write_en (write_en),
        .busin    (busin),
        .pc_inc   (pc_inc),
        .ac_clr   (ac_clr),
        .alu_we   (alu_we),
        .alu_out  (alu_out),
        .ar       (ar),
        .pc       (pc),
        .ir       (ir),
        .ac       (ac),
        .r1       (r1),
        .r2       (r2),
        .r3       (r3),
        .r4       (r4),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata)
`ifdef BUS_WR_ERR_CNT_EN
        ,
        .wr_err_cnt (wr_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  we;
        logic [16:0] busin;
        logic        pc_inc;
        logic        ac_clr;
        logic        alu_we;
        logic [11:0] alu_out;
        logic [7:0]  e_ar;
        logic [7:0]  e_pc;
        logic [11:0] e_ir;
        logic [11:0] e_ac;
        logic [11:0] e_r1;
        logic [11:0] e_r2;
        logic [11:0] e_r3;
        logic [11:0] e_r4;
        logic        e_dmwe;
        logic [7:0]  e_dmaddr;
        logic [11:0] e_dmwdata;
    } vec_t;

    localparam int NV = 27;
    vec_t vt [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic [3:0] we, input logic [16:0] b,
                         input logic pi, input logic ac_c, input logic aw, input logic [11:0] ao);
        rst_n    = rn;
        write_en = we;
        busin    = b;
        pc_inc   = pi;
        ac_clr   = ac_c;
        alu_we   = aw;
        alu_out  = ao;
    endtask

    initial begin
        //            rst we     busin     pi ac aw alu_out  ar     pc     ir       ac       r1       r2       r3       r4       we  addr   wdata
        vt[0]  = '{1'b0, 4'd7,  17'h1_0ABC, 1, 0, 1, 12'h456, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[1]  = '{1'b0, 4'd12, 17'h1_0ABC, 1, 1, 1, 12'h456, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[2]  = '{1'b1, 4'd0,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[3]  = '{1'b1, 4'd7,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'hABC, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[4]  = '{1'b1, 4'd8,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'hABC, 12'hABC, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[5]  = '{1'b1, 4'd9,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'hABC, 12'hABC, 12'hABC, 12'h000, 0, 8'h00, 12'h000};
        vt[6]  = '{1'b1, 4'd10, 17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[7]  = '{1'b1, 4'd4,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'hABC, 12'h000, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[8]  = '{1'b1, 4'd5,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[9]  = '{1'b1, 4'd1,  17'h1_0ABC, 0, 0, 0, 12'h000, 8'hBC, 8'h00, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[10] = '{1'b1, 4'd2,  17'h0_00FF, 0, 0, 0, 12'h000, 8'hBC, 8'hFF, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[11] = '{1'b1, 4'd0,  17'h0_0000, 1, 0, 0, 12'h000, 8'hBC, 8'h00, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[12] = '{1'b1, 4'd2,  17'h0_0010, 1, 0, 0, 12'h000, 8'hBC, 8'h10, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[13] = '{1'b1, 4'd3,  17'h1_FFFF, 0, 0, 0, 12'h000, 8'hBC, 8'h10, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[14] = '{1'b1, 4'd5,  17'h0_0123, 0, 1, 1, 12'h456, 8'hBC, 8'h10, 12'hABC, 12'h000, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[15] = '{1'b1, 4'd5,  17'h0_0123, 0, 0, 1, 12'h456, 8'hBC, 8'h10, 12'hABC, 12'h123, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[16] = '{1'b1, 4'd0,  17'h0_0000, 0, 0, 1, 12'h456, 8'hBC, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[17] = '{1'b1, 4'd1,  17'h0_0020, 0, 0, 0, 12'h000, 8'h20, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h00, 12'h000};
        vt[18] = '{1'b1, 4'd12, 17'h1_05A5, 0, 0, 0, 12'h000, 8'h20, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 1, 8'h20, 12'h5A5};
        vt[19] = '{1'b1, 4'd1,  17'h0_0030, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h20, 12'h5A5};
        vt[20] = '{1'b1, 4'd12, 17'h0_0111, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 1, 8'h30, 12'h111};
        vt[21] = '{1'b1, 4'd12, 17'h0_0222, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 1, 8'h30, 12'h222};
        vt[22] = '{1'b1, 4'd0,  17'h0_0999, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h30, 12'h222};
        vt[23] = '{1'b1, 4'd13, 17'h1_F777, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 0, 8'h30, 12'h222};
        vt[24] = '{1'b1, 4'd12, 17'h0_0333, 0, 0, 0, 12'h000, 8'h30, 8'h10, 12'hABC, 12'h456, 12'hABC, 12'hABC, 12'hABC, 12'hABC, 1, 8'h30, 12'h333};
        vt[25] = '{1'b0, 4'd12, 17'h0_0444, 1, 0, 1, 12'h777, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};
        vt[26] = '{1'b1, 4'd0,  17'h0_0000, 0, 0, 0, 12'h000, 8'h00, 8'h00, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 0, 8'h00, 12'h000};

        drive(1'b0, 4'd0, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst_n, vt[i].we, vt[i].busin, vt[i].pc_inc, vt[i].ac_clr, vt[i].alu_we, vt[i].alu_out);
            @(posedge clk);
            #1;
            chk("ar", i, 32'(ar), 32'(vt[i].e_ar));
            chk("pc", i, 32'(pc), 32'(vt[i].e_pc));
            chk("ir", i, 32'(ir), 32'(vt[i].e_ir));
            chk("ac", i, 32'(ac), 32'(vt[i].e_ac));
            chk("r1", i, 32'(r1), 32'(vt[i].e_r1));
            chk("r2", i, 32'(r2), 32'(vt[i].e_r2));
            chk("r3", i, 32'(r3), 32'(vt[i].e_r3));
            chk("r4", i, 32'(r4), 32'(vt[i].e_r4));
            chk("dm_we", i, 32'(dm_we), 32'(vt[i].e_dmwe));
            chk("dm_addr", i, 32'(dm_addr), 32'(vt[i].e_dmaddr));
            chk("dm_wdata", i, 32'(dm_wdata), 32'(vt[i].e_dmwdata));
            $display("vec %0d rst_n=%0d we=%0d busin=%h -> ar=%h pc=%h ac=%h dm_we=%0d dm_addr=%h dm_wdata=%h",
                     i, vt[i].rst_n, vt[i].we, vt[i].busin, ar, pc, ac, dm_we, dm_addr, dm_wdata);
        end

        // PC wrap from a sustained increment: FF -> 00 -> 01.
        drive(1'b1, 4'd2, 17'h1_00FF, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        drive(1'b1, 4'd0, 17'h0, 1'b1, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        chk("pc_wrap", 100, 32'(pc), 32'h00);
        @(posedge clk); #1;
        chk("pc_inc_after_wrap", 101, 32'(pc), 32'h01);
        $display("seq pc wrap -> pc=%h", pc);

`ifdef BUS_WR_ERR_CNT_EN
        drive(1'b0, 4'd0, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        chk("err_reset", 200, 32'(wr_err_cnt), 32'd0);
        drive(1'b1, 4'd0, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        drive(1'b1, 4'd12, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        chk("err_codes_0_12", 201, 32'(wr_err_cnt), 32'd0);
        drive(1'b1, 4'd6, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        chk("err_code_6", 202, 32'(wr_err_cnt), 32'd1);
        drive(1'b1, 4'd13, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        repeat (300) @(posedge clk);
        #1;
        chk("err_saturate", 203, 32'(wr_err_cnt), 32'd255);
        drive(1'b0, 4'd13, 17'h0, 1'b0, 1'b0, 1'b0, 12'h0);
        @(posedge clk); #1;
        chk("err_reset_clear", 204, 32'(wr_err_cnt), 32'd0);
        $display("seq err counter -> wr_err_cnt=%0d", wr_err_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
